// File: rtl/iir_pkg.sv
// Shared constants, sum type and saturation limits for the IIR notch filter datapath.
package iir_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_FRAC  = 30;
  localparam int LIM_W     = 64;

  typedef logic signed [2*DEF_WIDTH-1:0] sum_t;

  typedef struct packed {
    logic signed [LIM_W-1:0] max_v;
    logic signed [LIM_W-1:0] min_v;
  } sat_lim_t;

  // Extremes of a width-bit signed value, carried in LIM_W bits (width <= LIM_W).
  function automatic sat_lim_t sat_limits(input int width);
    sat_lim_t lim;
    lim.min_v = -(64'sd1 <<< (width - 1));
    lim.max_v = ~lim.min_v;
    return lim;
  endfunction

endpackage

// File: rtl/iir_round_sat.sv
// Combinational round-half-up / arithmetic shift and WIDTH-bit saturation, shared with the FIR path.
module iir_round_sat
  import iir_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC
) (
  input  logic signed [2*WIDTH-1:0] sum_i,
  output logic signed [2*WIDTH:0]   rnd_o,
  input  logic signed [2*WIDTH:0]   rnd_i,
  output logic signed [WIDTH-1:0]   y_o,
  output logic                      sat_o
);

  localparam int RW = 2*WIDTH + 1;
  localparam sat_lim_t LIM = sat_limits(WIDTH);
  localparam logic signed [RW-1:0] Y_MAX = RW'(LIM.max_v);
  localparam logic signed [RW-1:0] Y_MIN = RW'(LIM.min_v);
  localparam logic signed [RW-1:0] HALF  = RW'(1) <<< (FRAC - 1);

  logic signed [RW-1:0] ext;

  // The extra MSB absorbs the rounding carry, so the add never wraps.
  assign ext   = {sum_i[2*WIDTH-1], sum_i} + HALF;
  assign rnd_o = ext >>> FRAC;

  always_comb begin
    y_o   = rnd_i[WIDTH-1:0];
    sat_o = 1'b0;
    if (rnd_i > Y_MAX) begin
      y_o   = Y_MAX[WIDTH-1:0];
      sat_o = 1'b1;
    end else if (rnd_i < Y_MIN) begin
      y_o   = Y_MIN[WIDTH-1:0];
      sat_o = 1'b1;
    end
  end

endmodule

// File: rtl/iir_requant.sv
// Two-stage requantizer (round/shift, then saturate) with valid/ready output and y[n-1]/y[n-2] taps.
// Define IIR_REQUANT_SAT_CNT_EN to build the saturation counter; otherwise sat_count reads 0.
module iir_requant
  import iir_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC,
  parameter int CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic signed [2*WIDTH-1:0] s_sum,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic signed [WIDTH-1:0]   m_y,
  output logic signed [WIDTH-1:0]   y_d1,
  output logic signed [WIDTH-1:0]   y_d2,
  output logic                      sat_flag,
  output logic [CNT_W-1:0]          sat_count
);

  localparam int RW = 2*WIDTH + 1;

  logic                    stall, accept, xfer;
  logic signed [RW-1:0]    rnd_a, rnd_p1_q;
  logic signed [WIDTH-1:0] y_b;
  logic                    sat_b;
  logic                    vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
  logic signed [WIDTH-1:0] y_p2_q, y_p2_d;
  logic                    sat_p2_q, sat_p2_d;
  logic signed [WIDTH-1:0] yd1_q, yd1_d, yd2_q, yd2_d;

  assign stall   = vld_p2_q & ~m_ready;
  assign accept  = s_valid & ~stall;
  assign xfer    = vld_p2_q & m_ready;
  assign s_ready = ~stall;

  iir_round_sat #(.WIDTH(WIDTH), .FRAC(FRAC)) u_round_sat (
    .sum_i (s_sum),
    .rnd_o (rnd_a),
    .rnd_i (rnd_p1_q),
    .y_o   (y_b),
    .sat_o (sat_b)
  );

  // Stage A -> p1: rounded sum, data only, qualified by vld_p1_q.
  always_ff @(posedge clk) begin
    if (accept) rnd_p1_q <= rnd_a;
  end

  // p1 -> p2: saturated sample on m_y; taps shift on transfer; clear overrides everything.
  always_comb begin
    vld_p1_d = vld_p1_q;
    vld_p2_d = vld_p2_q;
    y_p2_d   = y_p2_q;
    sat_p2_d = sat_p2_q;
    yd1_d    = yd1_q;
    yd2_d    = yd2_q;
    if (!stall) begin
      vld_p1_d = s_valid;
      vld_p2_d = vld_p1_q;
      if (vld_p1_q) begin
        y_p2_d   = y_b;
        sat_p2_d = sat_b;
      end
    end
    if (xfer) begin
      yd1_d = y_p2_q;
      yd2_d = yd1_q;
    end
    if (clear) begin
      vld_p1_d = 1'b0;
      vld_p2_d = 1'b0;
      y_p2_d   = '0;
      sat_p2_d = 1'b0;
      yd1_d    = '0;
      yd2_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      y_p2_q   <= '0;
      sat_p2_q <= 1'b0;
      yd1_q    <= '0;
      yd2_q    <= '0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      y_p2_q   <= y_p2_d;
      sat_p2_q <= sat_p2_d;
      yd1_q    <= yd1_d;
      yd2_q    <= yd2_d;
    end
  end

  assign m_valid  = vld_p2_q;
  assign m_y      = y_p2_q;
  assign sat_flag = sat_p2_q;
  assign y_d1     = yd1_q;
  assign y_d2     = yd2_q;

`ifdef IIR_REQUANT_SAT_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (xfer && sat_p2_q && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
    if (clear) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign sat_count = cnt_q;
`else
  assign sat_count = '0;
`endif

endmodule

// File: tb/tb_iir_requant.sv
// Self-checking bench for iir_requant at WIDTH=16, FRAC=14, with a CNT_W=2 twin for the counter cap.
`timescale 1ns/1ps
module tb_iir_requant;

  localparam int W = 16;
  localparam int F = 14;
`ifdef IIR_REQUANT_SAT_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic           clk = 1'b0, rst_n = 1'b1, clear = 1'b0, s_valid = 1'b0, m_ready = 1'b0;
  logic [2*W-1:0] s_sum = '0;
  logic           s_ready, m_valid, sat_flag;
  logic [W-1:0]   m_y, y_d1, y_d2;
  logic [15:0]    sat_count;
  logic           s_ready2, m_valid2, sat_flag2;
  logic [W-1:0]   m_y2, y_d1_2, y_d2_2;
  logic [1:0]     sat_count2;
  int             n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  iir_requant #(.WIDTH(W), .FRAC(F), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .s_valid(s_valid), .s_ready(s_ready),
    .s_sum(s_sum), .m_valid(m_valid), .m_ready(m_ready), .m_y(m_y), .y_d1(y_d1),
    .y_d2(y_d2), .sat_flag(sat_flag), .sat_count(sat_count)
  );

  iir_requant #(.WIDTH(W), .FRAC(F), .CNT_W(2)) dut_cap (
    .clk(clk), .rst_n(rst_n), .clear(clear), .s_valid(s_valid), .s_ready(s_ready2),
    .s_sum(s_sum), .m_valid(m_valid2), .m_ready(m_ready), .m_y(m_y2), .y_d1(y_d1_2),
    .y_d2(y_d2_2), .sat_flag(sat_flag2), .sat_count(sat_count2)
  );

  // Reference: y = floor(sum / 2^14 + 1/2), clipped to the 16-bit signed range.
  function automatic void model(input logic [31:0] sum, output logic [15:0] y, output logic sat);
    longint s, q;
    s = longint'($signed(sum)) + 64'sd8192;
    if (s >= 0) q = s / 16384;
    else        q = -((-s + 16383) / 16384);
    sat = 1'b1;
    if (q > 32767)       y = 16'h7FFF;
    else if (q < -32768) y = 16'h8000;
    else begin
      y   = q[15:0];
      sat = 1'b0;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    s_valid = 1'b0;
    clear   = 1'b1;
    step();
    clear   = 1'b0;
  endtask

  task automatic test_reset();
    logic [66:0] obs;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #3;
    obs = {m_valid, m_y, y_d1, y_d2, sat_flag, sat_count, s_ready};
    n_tests++;
    if (obs !== 67'h1) begin
      n_fail++;
      $display("FAIL reset_state: got %h want %h", obs, 67'h1);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    n_tests++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1 || sat_count2 !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_release: got m_valid=%b s_ready=%b cnt2=%0d want 0 1 0", m_valid, s_ready, sat_count2);
    end
  endtask

  task automatic test_rounding();
    logic [31:0] vin  [5] = '{32'h00002000, 32'h00001FFF, 32'h00006000, 32'hFFFFE000, 32'hFFFFDFFF};
    logic [15:0] vexp [5] = '{16'h0001, 16'h0000, 16'h0002, 16'h0000, 16'hFFFF};
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_sum   = vin[i];
      step();
      s_valid = 1'b0;
      n_tests++;
      if (m_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL round_latency_early[%0d]: got m_valid=%b want 0", i, m_valid);
      end
      step();
      n_tests++;
      if (m_valid !== 1'b1 || m_y !== vexp[i] || sat_flag !== 1'b0) begin
        n_fail++;
        $display("FAIL round_value[%0d]: got v=%b y=%h sat=%b want 1 %h 0", i, m_valid, m_y, sat_flag, vexp[i]);
      end
      step();
    end
  endtask

  task automatic test_saturation();
    logic [15:0] exp_cnt;
    exp_cnt = CNT_ON ? 16'd2 : 16'd0;
    do_clear();
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_sum   = 32'h7FFFFFFF;
    step();
    s_sum   = 32'h80000000;
    step();
    n_tests++;
    if (m_valid !== 1'b1 || m_y !== 16'h7FFF || sat_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_pos: got v=%b y=%h sat=%b want 1 7fff 1", m_valid, m_y, sat_flag);
    end
    s_valid = 1'b0;
    step();
    n_tests++;
    if (m_valid !== 1'b1 || m_y !== 16'h8000 || sat_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_neg: got v=%b y=%h sat=%b want 1 8000 1", m_valid, m_y, sat_flag);
    end
    step();
    n_tests++;
    if (sat_count !== exp_cnt || sat_count2 !== exp_cnt[1:0]) begin
      n_fail++;
      $display("FAIL sat_count_two: got %0d/%0d want %0d", sat_count, sat_count2, exp_cnt);
    end
  endtask

  task automatic test_counter_cap();
    logic [15:0] exp_cnt;
    logic [1:0]  exp_cap;
    exp_cnt = CNT_ON ? 16'd5 : 16'd0;
    exp_cap = CNT_ON ? 2'd3 : 2'd0;
    do_clear();
    m_ready = 1'b1;
    s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_sum = (i % 2 == 1) ? 32'h80000000 : 32'h7FFFFFFF;
      step();
    end
    s_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    n_tests++;
    if (sat_count2 !== exp_cap || sat_count !== exp_cnt) begin
      n_fail++;
      $display("FAIL cnt_cap: got cap=%0d full=%0d want %0d %0d", sat_count2, sat_count, exp_cap, exp_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] sums [4];
    logic [15:0] ey [$];
    logic [15:0] y, held;
    logic        s, acc, hold_valid;
    int          idx, got, stall_left;
    idx = 0; got = 0; stall_left = -1; hold_valid = 1'b0; held = '0;
    do_clear();
    for (int i = 0; i < 4; i++) begin
      sums[i] = $urandom;
      model(sums[i], y, s);
      ey.push_back(y);
    end
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      s_valid = (idx < 4);
      s_sum   = sums[idx < 4 ? idx : 0];
      if (m_valid && stall_left < 0) stall_left = 3;
      m_ready = !(stall_left > 0);
      #1;
      if (hold_valid) begin
        n_tests++;
        if (m_valid !== 1'b1 || m_y !== held) begin
          n_fail++;
          $display("FAIL bp_hold: got v=%b y=%h want 1 %h", m_valid, m_y, held);
        end
      end
      if (stall_left > 0) begin
        n_tests++;
        if (s_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_s_ready: got %b want 0", s_ready);
        end
      end
      if (m_valid && m_ready) begin
        n_tests++;
        if (m_y !== ey[got]) begin
          n_fail++;
          $display("FAIL bp_order[%0d]: got %h want %h", got, m_y, ey[got]);
        end
        got++;
      end
      hold_valid = m_valid && !m_ready;
      held       = m_y;
      acc        = s_valid && s_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
      if (stall_left > 0) stall_left--;
    end
    n_tests++;
    if (got != 4) begin
      n_fail++;
      $display("FAIL bp_count: got %0d transfers want 4", got);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if (m_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_duplicate: got m_valid=%b want 0", m_valid);
      end
      step();
    end
  endtask

  task automatic test_taps();
    int  nx;
    logic xf;
    nx = 0;
    do_clear();
    m_ready = 1'b1;
    for (int cyc = 0; cyc < 12 && nx < 3; cyc++) begin
      s_valid = (cyc < 3);
      s_sum   = 32'(cyc + 1) << 14;
      #1;
      xf = m_valid && m_ready;
      step();
      if (xf) nx++;
    end
    s_valid = 1'b0;
    n_tests++;
    if (nx != 3 || y_d1 !== 16'h0003 || y_d2 !== 16'h0002) begin
      n_fail++;
      $display("FAIL taps: got n=%0d d1=%h d2=%h want 3 0003 0002", nx, y_d1, y_d2);
    end
  endtask

  task automatic test_clear();
    logic [15:0] pre_cnt;
    logic [50:0] obs;
    pre_cnt = CNT_ON ? 16'd1 : 16'd0;
    do_clear();
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_sum   = 32'h7FFFFFFF;
    step();
    s_sum   = 32'h00004000;
    step();
    s_sum   = 32'h00008000;
    step();
    n_tests++;
    if (y_d1 !== 16'h7FFF || sat_count !== pre_cnt || m_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_pre: got d1=%h cnt=%0d v=%b want 7fff %0d 1", y_d1, sat_count, m_valid, pre_cnt);
    end
    s_sum = 32'h00002000;
    clear = 1'b1;
    step();
    clear   = 1'b0;
    s_valid = 1'b0;
    obs = {m_valid, m_y, y_d1, y_d2, sat_flag, sat_count[0]};
    n_tests++;
    if (obs !== 51'h0 || sat_count !== 16'h0) begin
      n_fail++;
      $display("FAIL clr_wins: got %h cnt=%0d want 0 0", obs, sat_count);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if (m_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL clr_no_valid[%0d]: got %b want 0", i, m_valid);
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [65:0] obs;
    do_clear();
    m_ready = 1'b1;
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_sum = 32'($urandom_range(0, 32'h0FFFFFFF));
      step();
    end
    m_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    obs = {m_valid, m_y, y_d1, y_d2, sat_flag, sat_count};
    n_tests++;
    if (obs !== 66'h0 || s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid: got %h s_ready=%b want 0 1", obs, s_ready);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    step();
    n_tests++;
    if (m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_flush: got m_valid=%b want 0", m_valid);
    end
  endtask

  task automatic test_random();
    logic [15:0] sb_y [$];
    logic        sb_s [$];
    logic [15:0] y, t1, t2;
    logic        s, acc;
    int          nsat;
    logic [15:0] exp_cnt;
    t1 = '0; t2 = '0; nsat = 0;
    do_clear();
    for (int cyc = 0; cyc < 320; cyc++) begin
      s_valid = (cyc < 300) && ($urandom % 4 != 0);
      case ($urandom % 4)
        0:       s_sum = $urandom;
        1:       s_sum = 32'($urandom_range(0, 32'h3FFFFFFF)) - 32'h20000000;
        2:       s_sum = 32'h1FFFC000 + 32'($urandom_range(0, 16383));
        default: s_sum = 32'hE0000000 - 32'($urandom_range(0, 16383));
      endcase
      m_ready = (cyc >= 300) || ($urandom % 4 != 0);
      #1;
      n_tests++;
      if (s_ready !== !(m_valid && !m_ready)) begin
        n_fail++;
        $display("FAIL rnd_s_ready[%0d]: got %b want %b", cyc, s_ready, !(m_valid && !m_ready));
      end
      if (m_valid && m_ready) begin
        n_tests++;
        if (sb_y.size() == 0) begin
          n_fail++;
          $display("FAIL rnd_spurious[%0d]: got y=%h want no sample", cyc, m_y);
        end else begin
          if (m_y !== sb_y[0] || sat_flag !== sb_s[0]) begin
            n_fail++;
            $display("FAIL rnd_data[%0d]: got %h/%b want %h/%b", cyc, m_y, sat_flag, sb_y[0], sb_s[0]);
          end
          t2 = t1;
          t1 = sb_y[0];
          if (sb_s[0]) nsat++;
          void'(sb_y.pop_front());
          void'(sb_s.pop_front());
        end
      end
      acc = s_valid && s_ready;
      if (acc) begin
        model(s_sum, y, s);
        sb_y.push_back(y);
        sb_s.push_back(s);
      end
      @(posedge clk);
      #1;
      n_tests++;
      if (y_d1 !== t1 || y_d2 !== t2) begin
        n_fail++;
        $display("FAIL rnd_taps[%0d]: got %h %h want %h %h", cyc, y_d1, y_d2, t1, t2);
      end
    end
    s_valid = 1'b0;
    exp_cnt = CNT_ON ? 16'(nsat) : 16'd0;
    n_tests++;
    if (sb_y.size() != 0 || sat_count !== exp_cnt) begin
      n_fail++;
      $display("FAIL rnd_drain: got left=%0d cnt=%0d want 0 %0d", sb_y.size(), sat_count, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_rounding();
    test_saturation();
    test_counter_cap();
    test_backpressure();
    test_taps();
    test_clear();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
